// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the memory port arbiter.
//   arb_state_t : arbiter FSM encoding (ARB / LOAD / DRAIN)
//   rd_tag_t    : owner of the single outstanding RAM read
//   gnt_t       : one-hot grant vector {l, d, f}
//   STARVE_LIMIT_DEF : default fetch starvation threshold
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB   = 2'b00,
    LOAD  = 2'b01,
    DRAIN = 2'b10
  } arb_state_t;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_F    = 2'd1,
    TAG_D    = 2'd2,
    TAG_L    = 2'd3
  } rd_tag_t;

  typedef struct packed {
    logic l;
    logic d;
    logic f;
  } gnt_t;

  localparam int unsigned STARVE_LIMIT_DEF = 3;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requester and RAM bus bundle for mem_port_arbiter.
//   f_*   : CPU instruction fetch port (read only)
//   d_*   : CPU data port (read/write)
//   l_*   : boot/debug loader port (read/write, optional bus lock)
//   mem_* : single-port synchronous RAM port
// Modports:
//   master : requesters + RAM side (drives reqs and mem_rdata)
//   slave  : the arbiter
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
);
  logic              f_req;
  logic [ADDR_W-1:0] f_addr;
  logic              f_gnt;
  logic              f_rvalid;
  logic [DATA_W-1:0] f_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;

  logic              l_req;
  logic              l_lock;
  logic              l_we;
  logic [ADDR_W-1:0] l_addr;
  logic [DATA_W-1:0] l_wdata;
  logic              l_gnt;
  logic              l_rvalid;
  logic [DATA_W-1:0] l_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output f_req, f_addr,
    input  f_gnt, f_rvalid, f_rdata,
    output d_req, d_we, d_addr, d_wdata,
    input  d_gnt, d_rvalid, d_rdata,
    output l_req, l_lock, l_we, l_addr, l_wdata,
    input  l_gnt, l_rvalid, l_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

  modport slave (
    input  f_req, f_addr,
    output f_gnt, f_rvalid, f_rdata,
    input  d_req, d_we, d_addr, d_wdata,
    output d_gnt, d_rvalid, d_rdata,
    input  l_req, l_lock, l_we, l_addr, l_wdata,
    output l_gnt, l_rvalid, l_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

endinterface

// File: rtl/mem_arb_priority.sv
// mem_arb_priority: combinational 3-way grant encoder.
//   f_req, d_req, l_req : requests
//   starve              : fetch has waited long enough to beat data
//   state               : arbiter FSM state
//   gnt                 : one-hot grant {l, d, f}, all zero when nothing wins
// ARB: L > D > F, except a starved fetch beats D. LOAD: L only. DRAIN: none.
module mem_arb_priority
  import mem_arb_pkg::*;
(
  input  logic       f_req,
  input  logic       d_req,
  input  logic       l_req,
  input  logic       starve,
  input  arb_state_t state,
  output gnt_t       gnt
);

  always_comb begin
    gnt = '0;
    unique case (state)
      ARB: begin
        if (l_req)                gnt.l = 1'b1;
        else if (starve && f_req) gnt.f = 1'b1;
        else if (d_req)           gnt.d = 1'b1;
        else if (f_req)           gnt.f = 1'b1;
      end
      LOAD:    gnt.l = l_req;
      default: gnt = '0;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port synchronous RAM between CPU
// fetch (F), CPU data (D) and the loader (L).
//   clk       : system clock, rising edge
//   rst       : synchronous active-low reset
//   bus       : requester ports and RAM port (mem_port_arbiter_if.slave)
//   cpu_stall : fetch not granted, or loader owns the bus (LOAD/DRAIN)
//   perf_*    : saturating event counters, present only when
//               MEM_ARB_PERF_EN is defined
// Read latency is one cycle; a 2-bit tag remembers which port owns the
// outstanding read so its rvalid/rdata can be routed back.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W       = 8,
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  mem_port_arbiter_if.slave    bus,
  output logic                 cpu_stall
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [15:0]          perf_stall_cycles,
  output logic [15:0]          perf_conflicts,
  output logic [15:0]          perf_starve_forces
`endif
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  arb_state_t        state_q, state_d;
  rd_tag_t           tag_q, tag_d;
  logic [3:0]        starve_cnt_q;
  logic              starve;
  gnt_t              gnt_raw, gnt;
  logic [DATA_W-1:0] f_rdata_q, d_rdata_q, l_rdata_q;
  logic [ADDR_W-1:0] addr_mux;
  logic [DATA_W-1:0] wdata_mux;
  logic              f_rv, d_rv, l_rv;

  assign starve = (starve_cnt_q == LIMIT) && bus.f_req;

  mem_arb_priority u_prio (
    .f_req  (bus.f_req),
    .d_req  (bus.d_req),
    .l_req  (bus.l_req),
    .starve (starve),
    .state  (state_q),
    .gnt    (gnt_raw)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state_q <= ARB;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ARB:     if (gnt.l && bus.l_lock) state_d = LOAD;
      LOAD:    if (!bus.l_lock)         state_d = DRAIN;
      DRAIN:   state_d = ARB;
      default: state_d = ARB;
    endcase
  end

  // Output logic: grants are suppressed while reset is asserted so the
  // RAM sees no access during reset.
  always_comb begin
    gnt       = rst ? gnt_raw : '0;
    addr_mux  = '0;
    wdata_mux = '0;
    if (gnt.l) begin
      addr_mux  = bus.l_addr;
      wdata_mux = bus.l_wdata;
    end else if (gnt.d) begin
      addr_mux  = bus.d_addr;
      wdata_mux = bus.d_wdata;
    end else if (gnt.f) begin
      addr_mux  = bus.f_addr;
    end
    bus.f_gnt     = gnt.f;
    bus.d_gnt     = gnt.d;
    bus.l_gnt     = gnt.l;
    bus.mem_en    = gnt.l | gnt.d | gnt.f;
    bus.mem_we    = (gnt.l & bus.l_we) | (gnt.d & bus.d_we);
    bus.mem_addr  = addr_mux;
    bus.mem_wdata = wdata_mux;
    cpu_stall     = (bus.f_req & ~gnt.f) | (state_q != ARB);
  end

  // Read tag: only a granted read leaves a tag behind.
  always_comb begin
    tag_d = TAG_NONE;
    if (gnt.l && !bus.l_we)      tag_d = TAG_L;
    else if (gnt.d && !bus.d_we) tag_d = TAG_D;
    else if (gnt.f)              tag_d = TAG_F;
  end

  // rvalid is gated by rst so a read in flight when reset arrives is dropped.
  assign f_rv = rst && (tag_q == TAG_F);
  assign d_rv = rst && (tag_q == TAG_D);
  assign l_rv = rst && (tag_q == TAG_L);

  always_ff @(posedge clk) begin
    if (!rst) begin
      tag_q     <= TAG_NONE;
      f_rdata_q <= '0;
      d_rdata_q <= '0;
      l_rdata_q <= '0;
    end else begin
      tag_q <= tag_d;
      if (f_rv) f_rdata_q <= bus.mem_rdata;
      if (d_rv) d_rdata_q <= bus.mem_rdata;
      if (l_rv) l_rdata_q <= bus.mem_rdata;
    end
  end

  // The returning byte is passed straight through in its valid cycle and
  // captured so non-target ports keep showing their last value.
  always_comb begin
    bus.f_rvalid = f_rv;
    bus.d_rvalid = d_rv;
    bus.l_rvalid = l_rv;
    bus.f_rdata  = f_rv ? bus.mem_rdata : f_rdata_q;
    bus.d_rdata  = d_rv ? bus.mem_rdata : d_rdata_q;
    bus.l_rdata  = l_rv ? bus.mem_rdata : l_rdata_q;
  end

  // Starvation counter: counts denied fetch cycles in ARB only.
  always_ff @(posedge clk) begin
    if (!rst) begin
      starve_cnt_q <= '0;
    end else if (state_q == ARB) begin
      if (gnt.f || !bus.f_req)     starve_cnt_q <= '0;
      else if (starve_cnt_q < LIMIT) starve_cnt_q <= starve_cnt_q + 4'd1;
    end
  end

`ifdef MEM_ARB_PERF_EN
  logic conflict;
  logic forced_f;

  assign conflict = (bus.f_req & bus.d_req) | (bus.f_req & bus.l_req) |
                    (bus.d_req & bus.l_req);
  // Only counts F grants that the normal priority would have given to D.
  assign forced_f = gnt.f && starve && bus.d_req;

  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_stall_cycles  <= '0;
      perf_conflicts     <= '0;
      perf_starve_forces <= '0;
    end else begin
      if (cpu_stall && perf_stall_cycles != '1)
        perf_stall_cycles <= perf_stall_cycles + 16'd1;
      if (conflict && perf_conflicts != '1)
        perf_conflicts <= perf_conflicts + 16'd1;
      if (forced_f && perf_starve_forces != '1)
        perf_starve_forces <= perf_starve_forces + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  logic clk;
  logic rst;
  logic cpu_stall;
  int   total = 0;
  int   bad   = 0;

  logic [7:0] ram [0:255] = '{default: 8'h00};

`ifdef MEM_ARB_PERF_EN
  logic [15:0] perf_stall_cycles, perf_conflicts, perf_starve_forces;
`endif

  mem_port_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  mem_port_arbiter #(.ADDR_W(8), .DATA_W(8), .STARVE_LIMIT(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .cpu_stall (cpu_stall)
`ifdef MEM_ARB_PERF_EN
    ,
    .perf_stall_cycles  (perf_stall_cycles),
    .perf_conflicts     (perf_conflicts),
    .perf_starve_forces (perf_starve_forces)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous single-port RAM model
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata     <= ram[bus.mem_addr];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [5:0] exp_f;

  initial begin
    ram[8'h00] <= 8'h11;
    ram[8'h10] <= 8'hC3;
    ram[8'h30] <= 8'h3C;
    ram[8'h40] <= 8'h77;
    exp_f = 6'b001000;

    rst = 1'b0;
    bus.f_req = 1'b1; bus.f_addr = 8'h00;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 8'h00; bus.d_wdata = 8'h00;
    bus.l_req = 1'b1; bus.l_lock = 1'b0; bus.l_we = 1'b0;
    bus.l_addr = 8'h00; bus.l_wdata = 8'h00;

    // Reset with every request high
    @(negedge clk); #1;
    chk("rst_gnt0", {13'd0, bus.l_gnt, bus.d_gnt, bus.f_gnt}, 16'h0);
    chk("rst_memen0", {15'd0, bus.mem_en}, 16'h0);
    chk("rst_stall0", {15'd0, cpu_stall}, 16'h1);
    @(negedge clk); #1;
    chk("rst_gnt1", {13'd0, bus.l_gnt, bus.d_gnt, bus.f_gnt}, 16'h0);
    chk("rst_rvalid", {13'd0, bus.l_rvalid, bus.d_rvalid, bus.f_rvalid}, 16'h0);
    chk("rst_rdata", {bus.f_rdata, bus.d_rdata ^ bus.l_rdata}, 16'h0);
    chk("rst_wr", {15'd0, bus.mem_we}, 16'h0);

    @(negedge clk); rst = 1'b1; #1;
    chk("post_rst_gnt", {13'd0, bus.l_gnt, bus.d_gnt, bus.f_gnt}, 16'h4);
    chk("post_rst_addr", {8'd0, bus.mem_addr}, 16'h0);
    @(negedge clk); bus.f_req = 1'b0; bus.d_req = 1'b0; bus.l_req = 1'b0; #1;
    chk("l_rvalid", {15'd0, bus.l_rvalid}, 16'h1);
    chk("l_rdata", {8'd0, bus.l_rdata}, 16'h11);

    // Fetch only
    @(negedge clk); bus.f_req = 1'b1; bus.f_addr = 8'h10; #1;
    chk("fetch_gnt", {15'd0, bus.f_gnt}, 16'h1);
    chk("fetch_addr", {8'd0, bus.mem_addr}, 16'h10);
    chk("fetch_stall", {15'd0, cpu_stall}, 16'h0);
    @(negedge clk); bus.f_req = 1'b0; #1;
    chk("fetch_rvalid", {15'd0, bus.f_rvalid}, 16'h1);
    chk("fetch_rdata", {8'd0, bus.f_rdata}, 16'hC3);
    chk("fetch_stall2", {15'd0, cpu_stall}, 16'h0);
    chk("fetch_d_rv", {15'd0, bus.d_rvalid}, 16'h0);

    // D/F conflict with starvation override on the fourth cycle
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 0) begin
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 8'h30;
        bus.f_req = 1'b1; bus.f_addr = 8'h40;
      end
      #1;
      chk("conf_f", {15'd0, bus.f_gnt}, {15'd0, exp_f[i]});
      chk("conf_d", {15'd0, bus.d_gnt}, {15'd0, ~exp_f[i]});
      chk("conf_stall", {15'd0, cpu_stall}, {15'd0, ~exp_f[i]});
      if (i == 1) chk("conf_d_rdata", {7'd0, bus.d_rvalid, bus.d_rdata}, 16'h13C);
      if (i == 4) chk("conf_f_rdata", {7'd0, bus.f_rvalid, bus.f_rdata}, 16'h177);
    end
    @(negedge clk); bus.d_req = 1'b0; bus.f_req = 1'b0; #1;
    chk("conf_tail_rv", {15'd0, bus.d_rvalid}, 16'h1);

    // Data write then read-back
    @(negedge clk); bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 8'h20;
    bus.d_wdata = 8'h5A; #1;
    chk("wr_gnt", {15'd0, bus.d_gnt}, 16'h1);
    chk("wr_we", {15'd0, bus.mem_we}, 16'h1);
    chk("wr_bus", {bus.mem_addr, bus.mem_wdata}, 16'h205A);
    @(negedge clk); bus.d_we = 1'b0; #1;
    chk("wr_no_rv", {15'd0, bus.d_rvalid}, 16'h0);
    chk("rd_gnt", {14'd0, bus.d_gnt, bus.mem_we}, 16'h2);
    @(negedge clk); bus.d_req = 1'b0; #1;
    chk("rd_rdata", {7'd0, bus.d_rvalid, bus.d_rdata}, 16'h15A);
    chk("f_rdata_hold", {8'd0, bus.f_rdata}, 16'h77);

    // Loader lock: 4 writes while fetch waits
    @(negedge clk); bus.f_req = 1'b1; bus.f_addr = 8'h00;
    bus.l_req = 1'b1; bus.l_lock = 1'b1; bus.l_we = 1'b1;
    bus.l_addr = 8'h00; bus.l_wdata = 8'hA0; #1;
    chk("ld0_gnt", {13'd0, bus.l_gnt, bus.d_gnt, bus.f_gnt}, 16'h4);
    chk("ld0_stall", {14'd0, cpu_stall, bus.mem_we}, 16'h3);
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      bus.l_addr = 8'(i); bus.l_wdata = 8'(8'hA0 + i);
      bus.d_req = (i == 2);
      #1;
      chk("ld_gnt", {13'd0, bus.l_gnt, bus.d_gnt, bus.f_gnt}, 16'h4);
      chk("ld_stall", {15'd0, cpu_stall}, 16'h1);
    end
    @(negedge clk); bus.d_req = 1'b0; bus.l_req = 1'b0; bus.l_lock = 1'b0;
    bus.l_we = 1'b0; #1;
    chk("ld_exit_f", {14'd0, bus.f_gnt, cpu_stall}, 16'h1);
    @(negedge clk); #1;
    chk("drain_f", {13'd0, bus.f_gnt, cpu_stall, bus.mem_en}, 16'h2);
    @(negedge clk); #1;
    chk("post_drain_f", {14'd0, bus.f_gnt, cpu_stall}, 16'h2);
    chk("post_drain_addr", {8'd0, bus.mem_addr}, 16'h0);
    @(negedge clk); bus.f_req = 1'b0; #1;
    chk("loaded_byte", {7'd0, bus.f_rvalid, bus.f_rdata}, 16'h1A0);

    // Reset arriving while a data read is outstanding
    @(negedge clk); bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 8'h10; #1;
    chk("mid_gnt", {15'd0, bus.d_gnt}, 16'h1);
    #2 rst = 1'b0;
    @(negedge clk); bus.d_req = 1'b0; #1;
    chk("mid_rv", {15'd0, bus.d_rvalid}, 16'h0);
    chk("mid_rdata", {8'd0, bus.d_rdata}, 16'h0);
    @(negedge clk); rst = 1'b1; bus.f_req = 1'b1; bus.f_addr = 8'h10; #1;
    chk("mid_arb", {14'd0, bus.f_gnt, cpu_stall}, 16'h2);
    chk("mid_rv2", {15'd0, bus.d_rvalid}, 16'h0);
    @(negedge clk); bus.f_req = 1'b0; #1;
    chk("mid_fetch", {6'd0, bus.d_rvalid, bus.f_rvalid, bus.f_rdata}, 16'h1C3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous 8-bit RAM between three requesters: CPU instruction fetch (F), CPU data access (D: load/store/push/pop/IN/OUT), and the boot/debug loader (L).
- Sits between the CPU wrapper's fetch/data memory ports and the RAM.
- Raises a stall to the PC/CU when fetch is not granted.
- Handles per-cycle arbitration, read-data return routing, fetch starvation protection and loader bus ownership.

Parameters:
- ADDR_W, 8, address width of all ports and the RAM.
- DATA_W, 8, data width.
- STARVE_LIMIT, 3, consecutive denied fetch cycles before fetch is forced to top priority for one grant (legal range 1..15).

Ports:
- clk  in  1  system clock, all logic rising-edge.
- rst  in  1  synchronous active-low reset: sampled on the rising edge of clk, asserted when low.
- f_req  in  1  fetch request.
- f_addr  in  ADDR_W  fetch address (PC).
- f_gnt  out  1  fetch granted this cycle.
- f_rvalid  out  1  fetch read data valid (one cycle after f_gnt).
- f_rdata  out  DATA_W  instruction byte.
- d_req  in  1  data request.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  write data.
- d_gnt  out  1  data granted this cycle.
- d_rvalid  out  1  data read valid (one cycle after a granted read).
- d_rdata  out  DATA_W  read data.
- l_req  in  1  loader request.
- l_lock  in  1  loader requests exclusive ownership.
- l_we  in  1  loader write.
- l_addr  in  ADDR_W  loader address.
- l_wdata  in  DATA_W  loader write data.
- l_gnt  out  1  loader granted.
- l_rvalid  out  1  loader read valid.
- l_rdata  out  DATA_W  loader read data.
- mem_en  out  1  RAM access strobe.
- mem_we  out  1  RAM write enable.
- mem_addr  out  ADDR_W  RAM address.
- mem_wdata  out  DATA_W  RAM write data.
- mem_rdata  in  DATA_W  RAM read data (valid one cycle after mem_en & ~mem_we).
- cpu_stall  out  1  = f_req & ~f_gnt, or FSM not in ARB; holds PC and suppresses CPU state writes.

Behaviour:
- Reset (rst low at the clock edge):
  - FSM enters ARB and the starvation counter clears.
  - The outstanding read tag clears.
  - All gnt, rvalid, mem_en and mem_we outputs are 0; all rdata outputs are 0.
  - cpu_stall follows its equation, so it is 1 if f_req is high.
- Grants are combinational from the current requests and state. At most one gnt is high per cycle. The mem_* outputs are muxed from the granted requester; with no grant, mem_en = 0.
- Read latency is 1:
  - A granted read registers a 2-bit tag (NONE/F/D/L).
  - Next cycle, the tagged rvalid = 1 and its rdata = mem_rdata. The other rdata outputs hold their last value.
  - Writes produce no rvalid.
- FSM states:
  - ARB: normal arbitration.
    - Priority is L > D > F.
    - Exception: if starve_cnt == STARVE_LIMIT and f_req is high, F wins over D. L still wins.
    - An L grant with l_lock = 1 moves to LOAD.
  - LOAD: only L may be granted; f_gnt = d_gnt = 0; cpu_stall = 1. Stays while l_lock = 1. On l_lock = 0, moves to DRAIN.
  - DRAIN: one cycle with no grants and cpu_stall = 1, so the final loader read returns before the CPU restarts. Then moves to ARB.
- Starvation counter (4 bits):
  - Increments when f_req & ~f_gnt in ARB, saturating at STARVE_LIMIT.
  - Clears on f_gnt or ~f_req.
  - Holds in LOAD and DRAIN.
- Simultaneous D and F requests under no starvation: D is granted and cpu_stall = 1. The CPU keeps both requests stable until granted.
- A requester that drops req before gnt is allowed; nothing is issued for it.
- A read and a write to the same address in consecutive cycles: RAM ordering is preserved because one access is issued per cycle, strictly in grant order.
- Reset during LOAD or while a read is outstanding: the pending rvalid is suppressed, and control returns to ARB on the next cycle.

Optional Feature:
- Macro MEM_ARB_PERF_EN.
- When defined, adds three 16-bit saturating counters with output ports: perf_stall_cycles (cycles with cpu_stall = 1), perf_conflicts (cycles where at least 2 reqs are high), perf_starve_forces (F grants due to the starvation override). The counters clear on reset.
- When undefined, these ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Shared package mem_arb_pkg holds:
  - the FSM state encoding (ARB = 2'b00, LOAD = 2'b01, DRAIN = 2'b10);
  - the read-tag encoding (NONE = 0, F = 1, D = 2, L = 3);
  - the STARVE_LIMIT default constant.
- One sub-module, mem_arb_priority: the combinational 3-way grant encoder taking reqs, the starve flag and state, and producing a one-hot grant. The top module holds the FSM, counter, tag register and muxes.

Test Plan:
- Reset check: rst = 0 for 2 cycles with all reqs high → all gnt, rvalid and mem_en = 0; after release, the first grant goes to L.
- Fetch-only, addr 0x10: f_req = 1 → f_gnt same cycle, mem_addr = 0x10; next cycle f_rvalid = 1 and f_rdata = RAM[0x10]; cpu_stall = 0 throughout.
- Conflict and starvation: d_req and f_req held high for 6 cycles with STARVE_LIMIT = 3 → grant pattern D, D, D, F, D, D; cpu_stall = 1 except on the F cycle.
- Data write then read: write 0x5A to 0x20, then read 0x20 → d_rvalid one cycle after the read grant, d_rdata = 0x5A; no d_rvalid after the write.
- Loader lock:
  - l_lock held for 4 writes to 0x00–0x03 while f_req = 1 → f_gnt = 0 and cpu_stall = 1 during LOAD plus 1 DRAIN cycle.
  - The fetch of 0x00 after DRAIN returns the loaded byte.
- Reset mid-read: D read granted, rst = 0 on the next edge → d_rvalid stays 0 and the FSM is in ARB after reset.
